// File: rtl/abuf_reuse_sched.sv
// -----------------------------------------------------------------------------
// abuf_reuse_sched
// Read sequencer for the per-core activation buffer (ABUF). It replays one
// activation vector of cfg_vec_len words cfg_num_pass times to the MAC array.
// Passes 0..P-2 are non-destructive reuse reads. Each reuse pass is preceded
// by a rewind cycle that reloads the reuse pointer. The final pass is a
// consuming read.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   start, abort       job start pulse (sampled in IDLE) / synchronous abort
//   cfg_vec_len        words per vector (1..ABUF_DEPTH)
//   cfg_num_pass       passes per vector (>=1)
//   mac_ready          MAC can accept a word next cycle
//   abuf_empty         consume pointer == write pointer
//   abuf_reuse_empty   reuse pointer == write pointer
//   abuf_ren           consuming read strobe (combinational)
//   abuf_reuse_ren     reuse read strobe (combinational)
//   abuf_reuse_rst     reload reuse pointer; only together with abuf_reuse_ren
//   busy, done         job active / 1-cycle completion pulse
//   cfg_err            1-cycle pulse for a start carrying an illegal config
//   tag_*              registered tags describing the previous cycle's strobe
//   pass_idx, word_idx current pass / next word to issue
// -----------------------------------------------------------------------------
module abuf_reuse_sched #(
  parameter int ABUF_DEPTH = 64,
  parameter int LEN_W      = $clog2(ABUF_DEPTH) + 1,
  parameter int PASS_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  cfg_vec_len,
  input  logic [PASS_W-1:0] cfg_num_pass,
  input  logic              mac_ready,
  input  logic              abuf_empty,
  input  logic              abuf_reuse_empty,
  output logic              abuf_ren,
  output logic              abuf_reuse_ren,
  output logic              abuf_reuse_rst,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              tag_valid,
  output logic              tag_first,
  output logic              tag_last,
  output logic              tag_last_pass,
  output logic [PASS_W-1:0] pass_idx,
  output logic [LEN_W-1:0]  word_idx
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REWIND     = 3'd1,
    REUSE_RD   = 3'd2,
    CONSUME_RD = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  vec_len;
  logic [PASS_W-1:0] num_pass;
  logic              cfg_ok;
  logic              last_word;
  logic              data_strobe;
  logic [PASS_W-1:0] pass_inc;

  assign cfg_ok    = (cfg_vec_len != '0) && (cfg_vec_len <= LEN_W'(ABUF_DEPTH)) &&
                     (cfg_num_pass != '0);
  assign last_word = (word_idx == vec_len - LEN_W'(1));
  assign pass_inc  = pass_idx + PASS_W'(1);

  // The rewind strobe returns a dummy word, so it is not a data strobe.
  assign data_strobe = abuf_ren | (abuf_reuse_ren & ~abuf_reuse_rst);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy read strobes. Abort overrides everything so that no
  // strobe reaches the ABUF in the abort cycle.
  always_comb begin
    state_nxt      = state;
    abuf_ren       = 1'b0;
    abuf_reuse_ren = 1'b0;
    abuf_reuse_rst = 1'b0;
    case (state)
      IDLE: begin
        if (start && cfg_ok) begin
          state_nxt = (cfg_num_pass == PASS_W'(1)) ? CONSUME_RD : REWIND;
        end
      end
      REWIND: begin
        if (!abuf_empty && mac_ready) begin
          abuf_reuse_ren = 1'b1;
          abuf_reuse_rst = 1'b1;
          state_nxt      = REUSE_RD;
        end
      end
      REUSE_RD: begin
        if (!abuf_reuse_empty && mac_ready) begin
          abuf_reuse_ren = 1'b1;
          if (last_word) begin
            state_nxt = (pass_inc == num_pass - PASS_W'(1)) ? CONSUME_RD : REWIND;
          end
        end
      end
      CONSUME_RD: begin
        if (!abuf_empty && mac_ready) begin
          abuf_ren = 1'b1;
          if (last_word) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      state_nxt      = IDLE;
      abuf_ren       = 1'b0;
      abuf_reuse_ren = 1'b0;
      abuf_reuse_rst = 1'b0;
    end
  end

  // Config latch, pass/word counters, error pulse and the registered tags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vec_len       <= '0;
      num_pass      <= '0;
      pass_idx      <= '0;
      word_idx      <= '0;
      cfg_err       <= 1'b0;
      tag_valid     <= 1'b0;
      tag_first     <= 1'b0;
      tag_last      <= 1'b0;
      tag_last_pass <= 1'b0;
    end else begin
      cfg_err       <= start && (state == IDLE) && !abort && !cfg_ok;
      tag_valid     <= data_strobe;
      tag_first     <= data_strobe && (word_idx == '0);
      tag_last      <= data_strobe && last_word;
      tag_last_pass <= abuf_ren;
      if (abort) begin
        pass_idx <= '0;
        word_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && cfg_ok) begin
              vec_len  <= cfg_vec_len;
              num_pass <= cfg_num_pass;
              pass_idx <= '0;
              word_idx <= '0;
            end
          end
          REUSE_RD: begin
            if (abuf_reuse_ren) begin
              if (last_word) begin
                word_idx <= '0;
                pass_idx <= pass_inc;
              end else begin
                word_idx <= word_idx + LEN_W'(1);
              end
            end
          end
          CONSUME_RD: begin
            if (abuf_ren) begin
              word_idx <= last_word ? '0 : word_idx + LEN_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_abuf_reuse_sched.sv
// -----------------------------------------------------------------------------
// tb_abuf_reuse_sched
// Directed bench for abuf_reuse_sched. Inputs change 1 time unit after the
// rising edge and outputs are sampled 2 time units after it. Per-cycle
// expected output vectors are hand-written in the order
// {ren, reuse_ren, reuse_rst, tag_valid, tag_first, tag_last, tag_last_pass,
//  done, busy}.
// -----------------------------------------------------------------------------
module tb_abuf_reuse_sched;
  localparam int ABUF_DEPTH = 64;
  localparam int LEN_W      = 7;
  localparam int PASS_W     = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  cfg_vec_len = '0;
  logic [PASS_W-1:0] cfg_num_pass = '0;
  logic              mac_ready = 1'b0;
  logic              abuf_empty = 1'b0;
  logic              abuf_reuse_empty = 1'b0;
  logic              abuf_ren, abuf_reuse_ren, abuf_reuse_rst;
  logic              busy, done, cfg_err;
  logic              tag_valid, tag_first, tag_last, tag_last_pass;
  logic [PASS_W-1:0] pass_idx;
  logic [LEN_W-1:0]  word_idx;
  logic [8:0]        obs;

  int checks = 0;
  int failures = 0;

  abuf_reuse_sched #(
    .ABUF_DEPTH(ABUF_DEPTH),
    .LEN_W     (LEN_W),
    .PASS_W    (PASS_W)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .abort           (abort),
    .cfg_vec_len     (cfg_vec_len),
    .cfg_num_pass    (cfg_num_pass),
    .mac_ready       (mac_ready),
    .abuf_empty      (abuf_empty),
    .abuf_reuse_empty(abuf_reuse_empty),
    .abuf_ren        (abuf_ren),
    .abuf_reuse_ren  (abuf_reuse_ren),
    .abuf_reuse_rst  (abuf_reuse_rst),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .tag_valid       (tag_valid),
    .tag_first       (tag_first),
    .tag_last        (tag_last),
    .tag_last_pass   (tag_last_pass),
    .pass_idx        (pass_idx),
    .word_idx        (word_idx)
  );

  assign obs = {abuf_ren, abuf_reuse_ren, abuf_reuse_rst, tag_valid, tag_first,
                tag_last, tag_last_pass, done, busy};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns 1 unit after the edge that latched it.
  task automatic launch(input int vl, input int np);
    cfg_vec_len  = LEN_W'(vl);
    cfg_num_pass = PASS_W'(np);
    start        = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 9'b0 || pass_idx !== '0 || word_idx !== '0 || cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: obs=%b pass=%0d word=%0d err=%b, required all 0",
               obs, pass_idx, word_idx, cfg_err);
    end
    step();
    rstn      = 1'b1;
    mac_ready = 1'b1;
    step();
    #1;
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: obs=%b required %b", obs, 9'b0);
    end
    step();
  endtask

  task automatic test_single_pass();
    logic [8:0] e [1:6];
    e = '{9'b100_0000_01, 9'b100_1101_01, 9'b100_1001_01, 9'b100_1001_01,
          9'b000_1011_11, 9'b000_0000_00};
    launch(4, 1);
    for (int c = 1; c <= 6; c++) begin
      #1;
      checks++;
      if (obs !== e[c]) begin
        failures++;
        $display("[TB] FAIL single_pass c%0d: obs=%b required %b", c, obs, e[c]);
      end
      if (c <= 4) begin
        checks++;
        if (word_idx !== LEN_W'(c - 1)) begin
          failures++;
          $display("[TB] FAIL single_word_idx c%0d: got %0d required %0d", c, word_idx, c - 1);
        end
      end
      step();
    end
  endtask

  task automatic test_multi_pass();
    logic [8:0] e [1:13];
    int pexp [1:12];
    int ndone;
    e = '{9'b011_0000_01, 9'b010_0000_01, 9'b010_1100_01, 9'b010_1000_01,
          9'b011_1010_01, 9'b010_0000_01, 9'b010_1100_01, 9'b010_1000_01,
          9'b100_1010_01, 9'b100_1101_01, 9'b100_1001_01, 9'b000_1011_11,
          9'b000_0000_00};
    pexp = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    ndone = 0;
    launch(3, 3);
    for (int c = 1; c <= 13; c++) begin
      #1;
      if (done === 1'b1) ndone++;
      checks++;
      if (obs !== e[c]) begin
        failures++;
        $display("[TB] FAIL multi_pass c%0d: obs=%b required %b", c, obs, e[c]);
      end
      if (c <= 12) begin
        checks++;
        if (pass_idx !== PASS_W'(pexp[c])) begin
          failures++;
          $display("[TB] FAIL multi_pass_idx c%0d: got %0d required %0d", c, pass_idx, pexp[c]);
        end
      end
      step();
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("[TB] FAIL multi_done_count: got %0d required 1", ndone);
    end
  endtask

  task automatic test_mac_stall();
    logic [8:0] e [1:9];
    e = '{9'b011_0000_01, 9'b010_0000_01, 9'b000_1100_01, 9'b000_0000_01,
          9'b010_0000_01, 9'b100_1010_01, 9'b100_1101_01, 9'b000_1011_11,
          9'b000_0000_00};
    launch(2, 2);
    for (int c = 1; c <= 9; c++) begin
      mac_ready = !(c == 3 || c == 4);
      #1;
      checks++;
      if (obs !== e[c]) begin
        failures++;
        $display("[TB] FAIL mac_stall c%0d: obs=%b required %b", c, obs, e[c]);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (word_idx !== LEN_W'(1)) begin
          failures++;
          $display("[TB] FAIL stall_word_hold c%0d: got %0d required 1", c, word_idx);
        end
      end
      step();
    end
    mac_ready = 1'b1;
  endtask

  task automatic test_empty_wait();
    logic [8:0] e [1:7];
    e = '{9'b000_0000_01, 9'b000_0000_01, 9'b100_0000_01, 9'b100_1101_01,
          9'b100_1001_01, 9'b000_1011_11, 9'b000_0000_00};
    abuf_empty = 1'b1;
    launch(3, 1);
    for (int c = 1; c <= 7; c++) begin
      abuf_empty = (c <= 2);
      #1;
      checks++;
      if (obs !== e[c]) begin
        failures++;
        $display("[TB] FAIL empty_wait c%0d: obs=%b required %b", c, obs, e[c]);
      end
      if (c <= 3) begin
        checks++;
        if (word_idx !== '0) begin
          failures++;
          $display("[TB] FAIL empty_word_hold c%0d: got %0d required 0", c, word_idx);
        end
      end
      step();
    end
  endtask

  task automatic test_cfg_err();
    int lens [0:2];
    int passes [0:2];
    lens   = '{0, 4, 65};
    passes = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      launch(lens[k], passes[k]);
      #1;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || abuf_ren !== 1'b0 || abuf_reuse_ren !== 1'b0) begin
        failures++;
        $display("[TB] FAIL cfg_err_pulse k%0d: err=%b busy=%b ren=%b rren=%b required 1 0 0 0",
                 k, cfg_err, busy, abuf_ren, abuf_reuse_ren);
      end
      step();
      #1;
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL cfg_err_once k%0d: err=%b busy=%b required 0 0", k, cfg_err, busy);
      end
      step();
    end
  endtask

  task automatic test_start_while_busy();
    int nren;
    int ndone;
    nren  = 0;
    ndone = 0;
    abuf_empty = 1'b1;
    launch(2, 1);
    cfg_vec_len = LEN_W'(5);
    start       = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || abuf_ren !== 1'b0 || cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL busy_wait: busy=%b ren=%b err=%b required 1 0 0", busy, abuf_ren, cfg_err);
    end
    step();
    start = 1'b0;
    step();
    abuf_empty = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (abuf_ren === 1'b1) nren++;
      if (done === 1'b1) ndone++;
      step();
    end
    checks++;
    if (nren != 2 || ndone != 1) begin
      failures++;
      $display("[TB] FAIL start_ignored: ren_count=%0d done_count=%0d required 2 1", nren, ndone);
    end
  endtask

  task automatic test_abort_and_reset();
    int ndone;
    ndone = 0;
    launch(8, 2);
    for (int c = 1; c <= 6; c++) step();
    abort = 1'b1;
    #1;
    checks++;
    if (abuf_ren !== 1'b0 || abuf_reuse_ren !== 1'b0 || word_idx !== LEN_W'(5) || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_cycle: ren=%b rren=%b word=%0d busy=%b required 0 0 5 1",
               abuf_ren, abuf_reuse_ren, word_idx, busy);
    end
    step();
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || word_idx !== '0 || pass_idx !== '0 || tag_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle: busy=%b done=%b word=%0d pass=%0d tv=%b required all 0",
               busy, done, word_idx, pass_idx, tag_valid);
    end
    step();
    for (int c = 0; c < 4; c++) begin
      #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
      step();
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: active cycles=%0d required 0", ndone);
    end
    launch(4, 2);
    step();
    step();
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0 || pass_idx !== '0 || word_idx !== '0 || cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: obs=%b pass=%0d word=%0d required all 0", obs, pass_idx, word_idx);
    end
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_mac_stall();
    test_empty_wait();
    test_cfg_err();
    test_start_while_busy();
    test_abort_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
